mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer for the single-port unified memory shared by the pipeline's instruction-fetch (IF) and data-access (MEM) stages. It accepts held-level requests from both ports, grants one at a time, drives the fixed-latency memory, captures read data and returns a one-cycle acknowledge. The pipeline derives its stalls from `req & ~ack`. The block sits between the CPU core and the memory model instantiated under `CPU`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, memory read latency in cycles from the issue cycle to valid `mem_rdata`; must be ≥1

- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  instruction read request, held until `if_ack`
- `if_addr`  in  ADDR_W  instruction address
- `if_ack`  out  1  one-cycle pulse; `if_rdata` valid in the same cycle
- `if_rdata`  out  DATA_W  fetched word
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_be`  in  DATA_W/8  byte enables for writes
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_ack`  out  1  one-cycle pulse
- `d_rdata`  out  DATA_W  load data; valid while `d_ack` is high for reads
- `mem_en`  out  1  memory access strobe; high for exactly one cycle per access
- `mem_we`  out  1  write strobe, qualified by `mem_en`
- `mem_be`  out  DATA_W/8  byte enables
- `mem_addr`  out  ADDR_W  address
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data, valid exactly `MEM_LAT` cycles after the `mem_en` cycle

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Arbitrate among the pending requests.
  - On a grant, register the winner's address, write data, `we` and `be`, set `owner`, update `last_grant`, then go to ISSUE.
  - With no request pending, stay in IDLE.
- **ISSUE:**
  - `mem_en`=1; all `mem_*` outputs are driven from the registered copies.
  - Load `cnt` = MEM_LAT-1 and go to WAIT.
- **WAIT:**
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`==0 and the access is a read, capture `mem_rdata` into the owner's rdata register.
  - If `cnt`==0, go to RESP.
- **RESP:**
  - Pulse the owner's ack for one cycle.
  - Arbitrate in the same cycle, considering only the *other* port, because the acked port's `req` is still high this cycle.
  - On a grant, go to ISSUE; otherwise go to IDLE.
- **Arbitration:**
  - A single pending request wins.
  - When both are pending, grant the port that was not granted last (`last_grant`).
  - `last_grant` resets to IF, so the first contention goes to data.
- **Writes:**
  - Same sequence and latency as reads.
  - `d_rdata` is not updated on writes.
- **rdata outputs:** each holds its last captured value between acks; reset value is 0.
- **Requester rules:**
  - `req` and its payload must stay stable from assertion until ack.
  - Payload is sampled at grant.
  - If a `req` drops before ack, the transaction still completes and is acked.
- **`if_we`:** there is none; IF accesses are always reads with `mem_be` = all ones.

## Timing
- **Read latency:** request first seen in IDLE at cycle t → `mem_en` at t+1 → capture at t+1+MEM_LAT → ack at t+2+MEM_LAT. With MEM_LAT=2, ack arrives at t+4.
- **Back-to-back:** a contended second access issues in the cycle after RESP. Sustained throughput is one access per MEM_LAT+2 cycles.
- **Reset values:**
  - State = IDLE.
  - `mem_en`, `mem_we`, `if_ack`, `d_ack` = 0.
  - `mem_addr`, `mem_wdata`, `mem_be`, `if_rdata`, `d_rdata` = 0.
  - `cnt` = 0; `last_grant` = IF.
- **Reset mid-transaction:**
  - Abort immediately to IDLE; no ack is issued.
  - Any memory response still in flight is ignored.
  - Requesters keep `req` high and are re-served after reset.
- **No-issue guarantees:**
  - `mem_en` is never high outside ISSUE.
  - Both acks are never high in the same cycle.

## Structure
- **Shared `cpu_pkg`:**
  - State enum `arb_state_t` {IDLE, ISSUE, WAIT, RESP}.
  - Port id constants `PORT_IF`=0, `PORT_D`=1.
  - Default `MEM_LAT`.
- **Sub-module `arb_rr2`:**
  - Combinational two-requester round-robin picker.
  - Inputs: `req[1:0]`, `mask[1:0]`, `last`. Outputs: `gnt[1:0]`, `gnt_id`.
  - Reused by IDLE (mask = 00) and RESP (mask = owner).

## Test plan
- **Single IF read:** `if_req` at cycle 0, addr 0x0000_0040, memory returns 0x2402_0005 at issue+2 → `mem_en` at cycle 1, `if_ack` at cycle 4 with `if_rdata` = 0x2402_0005, `d_ack` stays 0.
- **Data write:** `d_req`, `we`=1, `be`=4'b0011, addr 0x100, wdata 0xDEAD_BEEF → one `mem_en` cycle with `mem_we`=1, `mem_be`=0011, `d_ack` 3 cycles later, `d_rdata` unchanged.
- **Simultaneous requests from reset:** `if_req` and `d_req` together at cycle 0 → data issues at cycle 1, IF issues at cycle 5, acks at cycles 4 (d) and 8 (IF).
- **Sustained contention:** both `req` always high, each re-asserted after its ack → grants strictly alternate D, IF, D, IF for 8 transactions, with no two `mem_en` cycles closer than 4 apart.
- **Reset during WAIT:** `rst` asserted at issue+1 for 1 cycle → no ack, outputs at reset values next cycle, held `if_req` re-issued 1 cycle after `rst` falls.
- **MEM_LAT=1 build:** single read → ack at t+3, with data captured exactly at issue+1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: arbiter state encoding, port ids and default memory latency.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int unsigned MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker; masked requesters are never granted.
module arb_rr2
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic [1:0] eff;

    always_comb begin
        eff    = req & ~mask;
        gnt    = '0;
        gnt_id = PORT_IF;
        // under contention the port not granted last wins
        if (eff == 2'b11) begin
            gnt_id = ~last;
        end else begin
            gnt_id = eff[1];
        end
        if (eff != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and data accesses onto a single-port fixed-latency memory and returns one-cycle acks.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t       state, state_nxt;
    logic             owner;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic             grant;
    logic [1:0]       arb_mask;
    logic [1:0]       gnt;
    logic             gnt_id;

    // in RESP the acked port still holds req, so it is masked out
    assign arb_mask = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    arb_rr2 u_arb (
        .req    ({d_req, if_req}),
        .mask   (arb_mask),
        .last   (last_grant),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        mem_en    = 1'b0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                if_ack = (owner == PORT_IF);
                d_ack  = (owner == PORT_D);
                if (|gnt) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_we = we_q & mem_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= PORT_IF;
            last_grant <= PORT_IF;
            cnt        <= '0;
            we_q       <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner      <= gnt_id;
                last_grant <= gnt_id;
                if (gnt_id == PORT_D) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    we_q      <= d_we;
                    mem_be    <= d_be;
                end else begin
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    we_q      <= 1'b0;
                    mem_be    <= {BE_W{1'b1}};
                end
            end
            if (state == ISSUE) begin
                cnt <= CNT_W'(MEM_LAT - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == WAIT && cnt == '0 && !we_q) begin
                if (owner == PORT_IF) if_rdata <= mem_rdata;
                else                  d_rdata  <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level timing/memory model.
module tb_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = DW / 8;
    localparam int          LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [DW-1:0] env_mem [256];
    logic [DW-1:0] ref_mem [256];
    int            rd_due[$];
    logic [DW-1:0] rd_val[$];

    int remain [2];
    int gap    [2];
    int maxgap;
    bit ack_prev [2];

    bit            busy;
    int            t_issue, t_ack, owner, last;
    logic [AW-1:0] t_addr;
    logic          t_we;
    logic [BW-1:0] t_be;
    logic [DW-1:0] t_wdata, t_rdata;
    logic [DW-1:0] exp_if, exp_d;

    int en_log[$];
    int ack_log[$];
    int if_ack_cyc, d_ack_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < int'(BW); i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic logic port_req(input int p);
        return (p == 0) ? if_req : d_req;
    endfunction

    task automatic new_req(input int p);
        logic [AW-1:0] a;
        a = {22'b0, 8'($urandom), 2'b00};
        if (p == 0) begin
            if_req  = 1'b1;
            if_addr = a;
        end else begin
            d_req   = 1'b1;
            d_addr  = a;
            d_we    = 1'($urandom_range(0, 1));
            d_be    = BW'($urandom);
            d_wdata = $urandom;
        end
    endtask

    // One clock cycle: requesters, memory model, output checks, reference decision, then the edge.
    task automatic cycle();
        bit en_exp, ea_if, ea_d;
        bit can [2];
        int w;
        for (int p = 0; p < 2; p++) begin
            if (ack_prev[p]) begin
                if (p == 0) if_req = 1'b0; else d_req = 1'b0;
                gap[p] = $urandom_range(0, maxgap);
            end
            if (!port_req(p) && remain[p] > 0) begin
                if (gap[p] == 0) begin
                    new_req(p);
                    remain[p]--;
                end else begin
                    gap[p]--;
                end
            end
        end

        if (mem_en === 1'b1) begin
            en_log.push_back(cyc);
            if (mem_we === 1'b1) begin
                env_mem[mem_addr[9:2]] = merge(env_mem[mem_addr[9:2]], mem_wdata, mem_be);
            end else begin
                rd_due.push_back(cyc + LAT);
                rd_val.push_back(env_mem[mem_addr[9:2]]);
            end
        end
        while (rd_due.size() > 0 && rd_due[0] < cyc) begin
            void'(rd_due.pop_front());
            void'(rd_val.pop_front());
        end
        if (rd_due.size() > 0 && rd_due[0] == cyc) begin
            mem_rdata = rd_val.pop_front();
            void'(rd_due.pop_front());
        end else begin
            mem_rdata = $urandom;
        end
        if (if_ack === 1'b1) begin if_ack_cyc = cyc; ack_log.push_back(0); end
        if (d_ack === 1'b1)  begin d_ack_cyc  = cyc; ack_log.push_back(1); end

        en_exp = busy && cyc == t_issue;
        chk("mem_en", 64'(mem_en), 64'(en_exp));
        if (en_exp) begin
            chk("mem_addr", 64'(mem_addr), 64'(t_addr));
            chk("mem_we", 64'(mem_we), 64'(t_we));
            chk("mem_be", 64'(mem_be), 64'(t_be));
            if (t_we) chk("mem_wdata", 64'(mem_wdata), 64'(t_wdata));
        end
        ea_if = busy && cyc == t_ack && owner == 0;
        ea_d  = busy && cyc == t_ack && owner == 1;
        chk("if_ack", 64'(if_ack), 64'(ea_if));
        chk("d_ack", 64'(d_ack), 64'(ea_d));
        if (ea_if) exp_if = t_rdata;
        if (ea_d && !t_we) exp_d = t_rdata;
        chk("if_rdata", 64'(if_rdata), 64'(exp_if));
        chk("d_rdata", 64'(d_rdata), 64'(exp_d));
        ack_prev[0] = ea_if;
        ack_prev[1] = ea_d;

        if (rst) begin
            busy   = 1'b0;
            last   = 0;
            exp_if = '0;
            exp_d  = '0;
        end else begin
            can[0] = 1'b0;
            can[1] = 1'b0;
            if (busy && cyc == t_ack) begin
                can[1-owner] = port_req(1 - owner);
            end else if (!busy || cyc > t_ack) begin
                can[0] = port_req(0);
                can[1] = port_req(1);
            end
            if (can[0] || can[1]) begin
                w       = (can[0] && can[1]) ? 1 - last : (can[1] ? 1 : 0);
                busy    = 1'b1;
                owner   = w;
                last    = w;
                t_issue = cyc + 1;
                t_ack   = cyc + 2 + LAT;
                if (w == 0) begin
                    t_addr = if_addr; t_we = 1'b0; t_be = '1; t_wdata = '0;
                end else begin
                    t_addr = d_addr; t_we = d_we; t_be = d_be; t_wdata = d_wdata;
                end
                if (t_we) ref_mem[t_addr[9:2]] = merge(ref_mem[t_addr[9:2]], t_wdata, t_be);
                else      t_rdata = ref_mem[t_addr[9:2]];
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int t0;
        int budget;
        int ndiff;

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        remain = '{0, 0}; gap = '{0, 0}; maxgap = 0; ack_prev = '{0, 0};
        busy = 1'b0; last = 0; owner = 0; t_issue = 0; t_ack = 0;
        t_addr = '0; t_we = 1'b0; t_be = '0; t_wdata = '0; t_rdata = '0;
        exp_if = '0; exp_d = '0;
        if_ack_cyc = -1; d_ack_cyc = -1;

        @(posedge clk);
        #1;
        cyc++;
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_if_ack", 64'(if_ack), 64'd0);
        chk("rst_d_ack", 64'(d_ack), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata), 64'd0);
        rst = 1'b0;

        // single IF read
        env_mem[16] = 32'h2402_0005; ref_mem[16] = 32'h2402_0005;
        en_log.delete();
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        repeat (7) cycle();
        chk("if_read_en_cycle", 64'(en_log.size() > 0 ? en_log[0] : -1), 64'(t0 + 1));
        chk("if_read_ack_cycle", 64'(if_ack_cyc), 64'(t0 + 4));
        chk("if_read_rdata", 64'(if_rdata), 64'h2402_0005);
        chk("if_read_no_d_ack", 64'(d_ack_cyc), 64'(-1));

        // data write with partial byte enables
        env_mem[64] = 32'h1122_3344; ref_mem[64] = 32'h1122_3344;
        en_log.delete();
        t0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        repeat (7) cycle();
        chk("wr_en_count", 64'(en_log.size()), 64'd1);
        chk("wr_ack_cycle", 64'(d_ack_cyc), 64'(t0 + 4));
        chk("wr_d_rdata_kept", 64'(d_rdata), 64'd0);
        chk("wr_mem_word", 64'(env_mem[64]), 64'h1122_BEEF);

        // simultaneous requests right after reset: data first
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        en_log.delete();
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0200;
        repeat (10) cycle();
        chk("both_d_issue", 64'(en_log.size() > 0 ? en_log[0] : -1), 64'(t0 + 1));
        chk("both_if_issue", 64'(en_log.size() > 1 ? en_log[1] : -1), 64'(t0 + 5));
        chk("both_d_ack", 64'(d_ack_cyc), 64'(t0 + 4));
        chk("both_if_ack", 64'(if_ack_cyc), 64'(t0 + 8));

        // sustained contention: strict alternation D, IF, ...
        en_log.delete();
        ack_log.delete();
        new_req(0);
        new_req(1);
        remain = '{3, 3};
        maxgap = 0;
        repeat (8 * (LAT + 2) + 4) cycle();
        chk("alt_count", 64'(ack_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++)
            chk("alt_order", 64'(ack_log[i]), 64'((i % 2 == 0) ? 1 : 0));
        for (int i = 1; i < 8 && i < en_log.size(); i++)
            chk("alt_issue_gap", 64'(en_log[i] - en_log[i-1]), 64'(LAT + 2));

        // reset one cycle after issue aborts the read; held request is re-served
        en_log.delete();
        if_ack_cyc = -1;
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0044;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_mem_en", 64'(mem_en), 64'd0);
        chk("abort_if_ack", 64'(if_ack), 64'd0);
        chk("abort_mem_addr", 64'(mem_addr), 64'd0);
        chk("abort_mem_be", 64'(mem_be), 64'd0);
        chk("abort_mem_wdata", 64'(mem_wdata), 64'd0);
        repeat (6) cycle();
        chk("abort_reissue", 64'(en_log.size() > 1 ? en_log[1] : -1), 64'(t0 + 4));
        chk("abort_ack_cycle", 64'(if_ack_cyc), 64'(t0 + 7));

        // randomized traffic
        remain = '{20, 20};
        gap = '{0, 0};
        maxgap = 3;
        budget = 0;
        while ((remain[0] > 0 || remain[1] > 0 || if_req || d_req) && budget < 2000) begin
            cycle();
            budget++;
        end
        chk("random_finished", 64'(budget < 2000), 64'd1);
        repeat (4) cycle();
        ndiff = 0;
        for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) ndiff++;
        chk("mem_image", 64'(ndiff), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
